bitmap_requester: RTL and testbench

Client-side front end for the bitmap slot allocator. It turns consumer allocate requests and release requests into the allocator's CLAIM/FREE/CONTROL protocol, and returns granted slot indices. It keeps a shadow bitmap of issued slots, so double releases are rejected and never reach the allocator. It sits between the pipeline stages that need tags or registers and the bitmap allocator instance.

---
 rtl/bitmap_pkg.sv | 20 ++
 rtl/bitmap_rel_fifo.sv | 52 +++++
 rtl/bitmap_requester.sv | 163 ++++++++++++++++
 tb/tb_bitmap_requester.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// Shared definitions for the bitmap allocator client: control encodings,
// requester FSM states and index-width helper.
package bitmap_pkg;

  localparam logic [1:0] FL_CLAIM_IDLE = 2'b01;
  localparam logic [1:0] FL_FREE_IDLE  = 2'b10;
  localparam logic [1:0] FL_IDLE       = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLAIM  = 2'd1,
    SETTLE = 2'd2,
    FREE   = 2'd3
  } req_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bitmap_rel_fifo.sv
// Show-ahead synchronous FIFO holding pending slot releases.
module bitmap_rel_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bitmap_requester.sv
// Client front end for the bitmap slot allocator: sequences claims and frees,
// tracks issued slots in a shadow bitmap and filters out invalid releases.
module bitmap_requester
  import bitmap_pkg::*;
#(
  parameter int LIST_SIZE = 32,
  parameter int REL_DEPTH = 4
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic                              ALLOC_REQ,
  output logic                              ALLOC_ACK,
  output logic [idx_width(LIST_SIZE)-1:0]   ALLOC_IDX,
  input  logic                              REL_VALID,
  output logic                              REL_READY,
  input  logic [idx_width(LIST_SIZE)-1:0]   REL_IDX,
  output logic                              REL_ERR,
  output logic [1:0]                        BM_CONTROL,
  output logic [idx_width(LIST_SIZE)-1:0]   BM_CLAIM,
  output logic [idx_width(LIST_SIZE)-1:0]   BM_FREE,
  input  logic [idx_width(LIST_SIZE)-1:0]   BM_AVAILABLE,
  input  logic                              BM_VALID,
  output logic [idx_width(LIST_SIZE):0]     OUTSTANDING
);

  localparam int IW = idx_width(LIST_SIZE);

  req_state_t           r_state,       w_state_next;
  logic [1:0]           r_ctrl,        w_ctrl_next;
  logic [IW-1:0]        r_claim,       w_claim_next;
  logic [IW-1:0]        r_free,        w_free_next;
  logic [IW-1:0]        r_alloc_idx,   w_alloc_idx_next;
  logic                 r_ack,         w_ack_next;
  logic                 r_err,         w_err_next;
  logic [LIST_SIZE-1:0] r_shadow,      w_shadow_next;
  logic [IW:0]          r_outstanding, w_outstanding_next;
  logic                 r_last_free,   w_last_free_next;
  logic                 r_free_settle, w_free_settle_next;
  logic                 r_live;

  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_can_claim;

  assign w_push    = REL_VALID && REL_READY;
  assign REL_READY = r_live && !w_full;

  bitmap_rel_fifo #(
    .WIDTH (IW),
    .DEPTH (REL_DEPTH)
  ) u_rel_fifo (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_push  (w_push),
    .i_data  (REL_IDX),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // While ACK is high the held request still belongs to the grant being acknowledged.
  assign w_can_claim = ALLOC_REQ && BM_VALID && !r_ack;

  always_comb begin
    w_state_next       = r_state;
    w_ctrl_next        = FL_IDLE;
    w_claim_next       = r_claim;
    w_free_next        = r_free;
    w_alloc_idx_next   = r_alloc_idx;
    w_ack_next         = 1'b0;
    w_err_next         = 1'b0;
    w_shadow_next      = r_shadow;
    w_outstanding_next = r_outstanding;
    w_last_free_next   = r_last_free;
    w_free_settle_next = 1'b0;
    w_pop              = 1'b0;
    case (r_state)
      IDLE: begin
        // The cycle right after a free is a no-op so the allocator outputs settle.
        if (!r_free_settle) begin
          if (w_can_claim && (w_empty || r_last_free)) begin
            w_claim_next     = BM_AVAILABLE;
            w_alloc_idx_next = BM_AVAILABLE;
            w_ctrl_next      = FL_FREE_IDLE;
            w_last_free_next = 1'b0;
            w_state_next     = CLAIM;
          end else if (!w_empty) begin
            w_pop = 1'b1;
            if (r_shadow[w_head]) begin
              w_free_next      = w_head;
              w_ctrl_next      = FL_CLAIM_IDLE;
              w_last_free_next = 1'b1;
              w_state_next     = FREE;
            end else begin
              w_err_next = 1'b1;
            end
          end
        end
      end
      CLAIM: begin
        w_shadow_next[r_claim] = 1'b1;
        w_outstanding_next     = r_outstanding + (IW+1)'(1);
        w_state_next           = SETTLE;
      end
      SETTLE: begin
        w_ack_next   = 1'b1;
        w_state_next = IDLE;
      end
      FREE: begin
        w_shadow_next[r_free] = 1'b0;
        w_outstanding_next    = r_outstanding - (IW+1)'(1);
        w_free_settle_next    = 1'b1;
        w_state_next          = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state       <= IDLE;
      r_ctrl        <= FL_IDLE;
      r_claim       <= '0;
      r_free        <= '0;
      r_alloc_idx   <= '0;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
      r_shadow      <= '0;
      r_outstanding <= '0;
      r_last_free   <= 1'b0;
      r_free_settle <= 1'b0;
      r_live        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ctrl        <= w_ctrl_next;
      r_claim       <= w_claim_next;
      r_free        <= w_free_next;
      r_alloc_idx   <= w_alloc_idx_next;
      r_ack         <= w_ack_next;
      r_err         <= w_err_next;
      r_shadow      <= w_shadow_next;
      r_outstanding <= w_outstanding_next;
      r_last_free   <= w_last_free_next;
      r_free_settle <= w_free_settle_next;
      r_live        <= 1'b1;
    end
  end

  assign ALLOC_ACK   = r_ack;
  assign ALLOC_IDX   = r_alloc_idx;
  assign REL_ERR     = r_err;
  assign BM_CONTROL  = r_ctrl;
  assign BM_CLAIM    = r_claim;
  assign BM_FREE     = r_free;
  assign OUTSTANDING = r_outstanding;

endmodule

// File: tb/tb_bitmap_requester.sv
// Directed bench for bitmap_requester with a behavioural lowest-free-first allocator.
module tb_bitmap_requester;

  localparam int LS = 32;
  localparam int IW = 5;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          ALLOC_REQ = 1'b0;
  logic          ALLOC_ACK;
  logic [IW-1:0] ALLOC_IDX;
  logic          REL_VALID = 1'b0;
  logic          REL_READY;
  logic [IW-1:0] REL_IDX = '0;
  logic          REL_ERR;
  logic [1:0]    BM_CONTROL;
  logic [IW-1:0] BM_CLAIM;
  logic [IW-1:0] BM_FREE;
  logic [IW-1:0] bm_avail;
  logic          bm_valid;
  logic [IW:0]   OUTSTANDING;

  int vectors = 0;
  int miscompares = 0;

  bitmap_requester #(.LIST_SIZE(LS), .REL_DEPTH(4)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .ALLOC_REQ    (ALLOC_REQ),
    .ALLOC_ACK    (ALLOC_ACK),
    .ALLOC_IDX    (ALLOC_IDX),
    .REL_VALID    (REL_VALID),
    .REL_READY    (REL_READY),
    .REL_IDX      (REL_IDX),
    .REL_ERR      (REL_ERR),
    .BM_CONTROL   (BM_CONTROL),
    .BM_CLAIM     (BM_CLAIM),
    .BM_FREE      (BM_FREE),
    .BM_AVAILABLE (bm_avail),
    .BM_VALID     (bm_valid),
    .OUTSTANDING  (OUTSTANDING)
  );

  always #5 CLK = ~CLK;

  // Allocator model: commits on the edge where an op is active, lowest free index first.
  logic [LS-1:0] used;
  always @(posedge CLK) begin
    if (!RSTN) begin
      used <= '0;
    end else begin
      if (!BM_CONTROL[0]) used[BM_CLAIM] <= 1'b1;
      if (!BM_CONTROL[1]) used[BM_FREE]  <= 1'b0;
    end
  end

  always_comb begin
    bm_avail = '0;
    bm_valid = 1'b0;
    for (int i = LS - 1; i >= 0; i--) begin
      if (!used[i]) begin
        bm_avail = IW'(i);
        bm_valid = 1'b1;
      end
    end
  end

  // Monitor: tallies ops and protocol violations, checked from the directed sequence.
  int            n_err = 0;
  int            n_free_cyc = 0;
  int            n_claim_cyc = 0;
  int            n_both = 0;
  int            n_bad_claim = 0;
  int            n_bad_free = 0;
  int            n_ops = 0;
  logic          log_en = 1'b0;
  logic          ops_log [16];
  logic [IW-1:0] last_free_idx = '0;

  always @(negedge CLK) begin
    if (RSTN) begin
      if (REL_ERR) n_err <= n_err + 1;
      if (BM_CONTROL == 2'b00) n_both <= n_both + 1;
      if (BM_CONTROL == 2'b10) begin
        n_claim_cyc <= n_claim_cyc + 1;
        if (used[BM_CLAIM] || !bm_valid) n_bad_claim <= n_bad_claim + 1;
        if (log_en && n_ops < 16) begin
          ops_log[n_ops] <= 1'b0;
          n_ops <= n_ops + 1;
        end
      end
      if (BM_CONTROL == 2'b01) begin
        n_free_cyc <= n_free_cyc + 1;
        last_free_idx <= BM_FREE;
        if (!used[BM_FREE]) n_bad_free <= n_bad_free + 1;
        if (log_en && n_ops < 16) begin
          ops_log[n_ops] <= 1'b1;
          n_ops <= n_ops + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("vec %0d %s observed=%0d expected=%0d", vectors, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!ALLOC_ACK && cycles < budget);
  endtask

  int c;
  int k;
  int e0;
  int f0;
  int c0;
  int acks;
  int act;

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_ctrl", BM_CONTROL, 2'b11);
    check("rst_claim", BM_CLAIM, 0);
    check("rst_free", BM_FREE, 0);
    check("rst_ack", ALLOC_ACK, 0);
    check("rst_err", REL_ERR, 0);
    check("rst_idx", ALLOC_IDX, 0);
    check("rst_out", OUTSTANDING, 0);
    check("rst_ready", REL_READY, 0);
    RSTN = 1'b1;
    step();
    check("ready_after_rst", REL_READY, 1);

    // First two grants: 3-cycle latency, then one grant per 4 cycles
    ALLOC_REQ = 1'b1;
    wait_ack(12, c);
    check("ack1_lat", c, 3);
    check("ack1_idx", ALLOC_IDX, 0);
    wait_ack(12, c);
    check("ack2_lat", c, 4);
    check("ack2_idx", ALLOC_IDX, 1);
    check("ack2_out", OUTSTANDING, 2);
    ALLOC_REQ = 1'b0;

    // Release of a never-granted slot is rejected
    e0 = n_err;
    f0 = n_free_cyc;
    REL_VALID = 1'b1;
    REL_IDX = 5'd9;
    step();
    REL_VALID = 1'b0;
    repeat (8) step();
    check("bad_rel_err", n_err - e0, 1);
    check("bad_rel_nofree", n_free_cyc - f0, 0);
    check("bad_rel_out", OUTSTANDING, 2);

    // Fill the allocator, then request while full
    ALLOC_REQ = 1'b1;
    for (int i = 2; i < LS; i++) begin
      wait_ack(12, c);
      check("fill_idx", ALLOC_IDX, i);
    end
    check("fill_out", OUTSTANDING, 32);
    acks = 0;
    act = 0;
    repeat (12) begin
      step();
      if (ALLOC_ACK) acks++;
      if (BM_CONTROL != 2'b11) act++;
    end
    check("full_no_ack", acks, 0);
    check("full_ctrl_idle", act, 0);
    REL_VALID = 1'b1;
    REL_IDX = 5'd5;
    step();
    REL_VALID = 1'b0;
    wait_ack(20, c);
    check("realloc_ack", ALLOC_ACK, 1);
    check("realloc_idx", ALLOC_IDX, 5);
    check("freed_idx", last_free_idx, 5);
    check("realloc_out", OUTSTANDING, 32);
    ALLOC_REQ = 1'b0;
    step();

    // Back-to-back releases with a concurrent request: queue fills, ops alternate
    f0 = n_free_cyc;
    c0 = n_claim_cyc;
    e0 = n_err;
    log_en = 1'b1;
    ALLOC_REQ = 1'b1;
    k = 0;
    while (k < 8 && REL_READY) begin
      REL_VALID = 1'b1;
      REL_IDX = IW'(k);
      step();
      k++;
    end
    REL_VALID = 1'b0;
    check("q_accepted", k, 5);
    check("q_ready_low", REL_READY, 0);
    repeat (60) step();
    ALLOC_REQ = 1'b0;
    log_en = 1'b0;
    step();
    check("mix_frees", n_free_cyc - f0, 5);
    check("mix_claims", n_claim_cyc - c0, 5);
    check("mix_errs", n_err - e0, 0);
    check("mix_out", OUTSTANDING, 32);
    check("mix_ops_logged", (n_ops >= 6) ? 1 : 0, 1);
    for (int i = 1; i < 6; i++) begin
      check("alt_ops", ops_log[i], !ops_log[i-1]);
    end

    // Reset in the middle of a claim
    REL_VALID = 1'b1;
    REL_IDX = 5'd7;
    ALLOC_REQ = 1'b1;
    step();
    REL_VALID = 1'b0;
    c = 0;
    while (BM_CONTROL != 2'b10 && c < 20) begin
      step();
      c++;
    end
    check("claim_before_rst", BM_CONTROL, 2'b10);
    RSTN = 1'b0;
    step();
    check("midrst_ctrl", BM_CONTROL, 2'b11);
    check("midrst_out", OUTSTANDING, 0);
    check("midrst_ack", ALLOC_ACK, 0);
    RSTN = 1'b1;
    wait_ack(12, c);
    check("postrst_lat", c, 3);
    check("postrst_idx", ALLOC_IDX, 0);
    ALLOC_REQ = 1'b0;
    step();
    check("postrst_out", OUTSTANDING, 1);

    // Protocol invariants seen by the monitor over the whole run
    check("never_both_ops", n_both, 0);
    check("claim_only_free_slot", n_bad_claim, 0);
    check("free_only_used_slot", n_bad_free, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
